// File: rtl/keypad_pkg.sv
// Shared constants, debounce state type and key-code helper for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS             = 4;
    localparam int KP_COLS             = 4;
    localparam int KP_KEYS             = KP_ROWS * KP_COLS;
    localparam int DEF_SCAN_DIV        = 50000;
    localparam int DEF_DEBOUNCE_FRAMES = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND_PRESS,
        ST_HELD,
        ST_PEND_RELEASE
    } deb_state_e;

    // True when exactly one key is set; ghosting and multi-key frames map to no key.
    function automatic logic is_single_key(input logic [KP_KEYS-1:0] v);
        return (v != '0) && ((v & (v - KP_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: tracks how long a snapshot stays stable and commits it to a one-hot key code.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic               clk,
    input  logic               RSTn,
    input  logic               frame_valid,
    input  logic [KP_KEYS-1:0] frame,
    output logic [KP_KEYS-1:0] onehot,
    output logic               key_press
);

    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_FRAMES);

    deb_state_e         state_q, state_d;
    logic [KP_KEYS-1:0] prev_q, prev_d;
    logic [KP_KEYS-1:0] committed_q, committed_d;
    logic [KP_KEYS-1:0] onehot_q, onehot_d;
    logic [3:0]         stable_q, stable_d;
    logic               key_press_q, key_press_d;

    logic               commit;
    logic [3:0]         stable_next;
    logic [KP_KEYS-1:0] new_code;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        prev_d      = prev_q;
        committed_d = committed_q;
        onehot_d    = onehot_q;
        stable_d    = stable_q;
        key_press_d = 1'b0;
        commit      = 1'b0;
        new_code    = '0;

        if (frame != prev_q)
            stable_next = 4'd1;
        else if (stable_q >= DEB_MAX)
            stable_next = DEB_MAX;
        else
            stable_next = stable_q + 4'd1;

        if (frame_valid) begin
            prev_d   = frame;
            stable_d = stable_next;

            unique case (state_q)
                ST_IDLE: begin
                    if (frame != '0)
                        state_d = ST_PEND_PRESS;
                end
                ST_PEND_PRESS: begin
                    if (frame == '0)
                        state_d = ST_IDLE;
                    else if (stable_next == DEB_MAX)
                        commit = 1'b1;
                end
                ST_HELD: begin
                    if (frame != committed_q)
                        state_d = ST_PEND_RELEASE;
                end
                ST_PEND_RELEASE: begin
                    if (frame == committed_q)
                        state_d = ST_HELD;
                    else if (stable_next == DEB_MAX)
                        commit = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase

            if (commit) begin
                committed_d = frame;
                state_d     = (frame != '0) ? ST_HELD : ST_IDLE;
                new_code    = is_single_key(frame) ? frame : '0;
                onehot_d    = new_code;
                key_press_d = (new_code != '0) && (new_code != onehot_q);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            committed_q <= '0;
            onehot_q    <= '0;
            stable_q    <= '0;
            key_press_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            committed_q <= committed_d;
            onehot_q    <= onehot_d;
            stable_q    <= stable_d;
            key_press_q <= key_press_d;
        end
    end

    assign onehot    = onehot_q;
    assign key_press = key_press_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: synchronizes column returns, walks the rows and assembles
// one 16-bit snapshot per frame for the debounce stage.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = DEF_SCAN_DIV,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic               clk,
    input  logic               RSTn,
    input  logic [KP_COLS-1:0] col_n,
    output logic [KP_ROWS-1:0] row_n,
    output logic [KP_KEYS-1:0] onehot,
    output logic               key_press
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [KP_COLS-1:0] sync1_q, sync1_d;
    logic [KP_COLS-1:0] sync2_q, sync2_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         row_q, row_d;
    logic [KP_ROWS-1:0] row_n_q, row_n_d;
    logic [KP_KEYS-1:0] acc_q, acc_d;

    logic               frame_valid;
    logic [KP_KEYS-1:0] snapshot;

    always_comb begin
        sync1_d     = col_n;
        sync2_d     = sync1_q;
        div_d       = div_q + DIV_W'(1);
        row_d       = row_q;
        acc_d       = acc_q;
        frame_valid = 1'b0;

        // Sampling in the last cycle of a row leaves the synchronizer time to settle after the row switch.
        if (div_q == DIV_LAST) begin
            div_d = '0;
            row_d = row_q + 2'd1;
            acc_d[int'(row_q) * KP_COLS +: KP_COLS] = ~sync2_q;
            if (row_q == 2'(KP_ROWS - 1))
                frame_valid = 1'b1;
        end
        snapshot = acc_d;

        row_n_d        = '1;
        row_n_d[row_d] = 1'b0;
    end

    // NOTE: the synchronizer resets to all-ones (no key) so reset release never shows a phantom press.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= '1;
            sync2_q <= '1;
            div_q   <= '0;
            row_q   <= '0;
            row_n_q <= 4'b1110;
            acc_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
            row_q   <= row_d;
            row_n_q <= row_n_d;
            acc_q   <= acc_d;
        end
    end

    assign row_n = row_n_q;

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .RSTn       (RSTn),
        .frame_valid(frame_valid),
        .frame      (snapshot),
        .onehot     (onehot),
        .key_press  (key_press)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scan;

    logic        clk  = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] onehot;
    logic        key_press;
    logic [15:0] keys = '0;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int press_cnt = 0;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .clk      (clk),
        .RSTn     (RSTn),
        .col_n    (col_n),
        .row_n    (row_n),
        .onehot   (onehot),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    // Matrix model: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !row_n[r])
                    col_n[c] = 1'b0;
    end

    always @(negedge clk)
        if (RSTn && key_press)
            press_cnt++;

    // Cycle 0 is the negedge where reset is released; cycle n is n negedges later.
    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        RSTn = 1'b0;
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        cyc  = 0;
    endtask

    task automatic test_reset();
        keys = '0;
        RSTn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL reset_row_n got=%b want=1110", row_n); end
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL reset_onehot got=%h want=0000", onehot); end
        total++; if (key_press !== 1'b0) begin bad++; $display("FAIL reset_key_press got=%b want=0", key_press); end
    endtask

    task automatic test_scan();
        int         base;
        logic [3:0] exp_row;
        base = press_cnt;
        RSTn = 1'b1;
        cyc  = 0;
        for (int j = 0; j < 40; j++) begin
            goto(j);
            exp_row = 4'b1111;
            exp_row[(j / 4) % 4] = 1'b0;
            total++; if (row_n !== exp_row) begin bad++; $display("FAIL scan_row_n cyc=%0d got=%b want=%b", j, row_n, exp_row); end
            total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL scan_onehot cyc=%0d got=%h want=0000", j, onehot); end
        end
        total++; if (press_cnt - base != 0) begin bad++; $display("FAIL scan_presses got=%0d want=0", press_cnt - base); end
    endtask

    task automatic test_single_key();
        int base;
        base = press_cnt;
        keys = 16'h0200;
        do_reset();
        goto(47);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL single_early got=%h want=0000", onehot); end
        goto(48);
        total++; if (onehot !== 16'h0200) begin bad++; $display("FAIL single_commit got=%h want=0200", onehot); end
        total++; if (key_press !== 1'b1) begin bad++; $display("FAIL single_pulse got=%b want=1", key_press); end
        goto(49);
        total++; if (key_press !== 1'b0) begin bad++; $display("FAIL single_pulse_len got=%b want=0", key_press); end
        goto(160);
        total++; if (onehot !== 16'h0200) begin bad++; $display("FAIL single_hold got=%h want=0200", onehot); end
        keys = '0;
        goto(207);
        total++; if (onehot !== 16'h0200) begin bad++; $display("FAIL single_release_early got=%h want=0200", onehot); end
        goto(208);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL single_release got=%h want=0000", onehot); end
        total++; if (key_press !== 1'b0) begin bad++; $display("FAIL single_release_pulse got=%b want=0", key_press); end
        goto(224);
        total++; if (press_cnt - base != 1) begin bad++; $display("FAIL single_presses got=%0d want=1", press_cnt - base); end
    endtask

    task automatic test_short_press();
        int base;
        base = press_cnt;
        keys = 16'h0001;
        do_reset();
        goto(32);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL bounce_mid got=%h want=0000", onehot); end
        keys = '0;
        goto(96);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL bounce_after got=%h want=0000", onehot); end
        total++; if (press_cnt - base != 0) begin bad++; $display("FAIL bounce_presses got=%0d want=0", press_cnt - base); end
    endtask

    task automatic test_multi_key();
        int base;
        base = press_cnt;
        keys = 16'h0090;
        do_reset();
        goto(48);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL multi_commit got=%h want=0000", onehot); end
        total++; if (key_press !== 1'b0) begin bad++; $display("FAIL multi_pulse got=%b want=0", key_press); end
        goto(80);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL multi_hold got=%h want=0000", onehot); end
        keys = '0;
        goto(144);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL multi_release got=%h want=0000", onehot); end
        total++; if (press_cnt - base != 0) begin bad++; $display("FAIL multi_presses got=%0d want=0", press_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = press_cnt;
        keys = 16'h8000;
        do_reset();
        goto(48);
        total++; if (onehot !== 16'h8000) begin bad++; $display("FAIL slide_first got=%h want=8000", onehot); end
        total++; if (key_press !== 1'b1) begin bad++; $display("FAIL slide_first_pulse got=%b want=1", key_press); end
        keys = 16'h0004;
        goto(95);
        total++; if (onehot !== 16'h8000) begin bad++; $display("FAIL slide_early got=%h want=8000", onehot); end
        goto(96);
        total++; if (onehot !== 16'h0004) begin bad++; $display("FAIL slide_second got=%h want=0004", onehot); end
        total++; if (key_press !== 1'b1) begin bad++; $display("FAIL slide_second_pulse got=%b want=1", key_press); end
        goto(112);
        total++; if (press_cnt - base != 2) begin bad++; $display("FAIL slide_presses got=%0d want=2", press_cnt - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        keys = 16'h0400;
        do_reset();
        goto(24);
        RSTn = 1'b0;
        #1;
        total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL midrst_row_n got=%b want=1110", row_n); end
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL midrst_onehot got=%h want=0000", onehot); end
        total++; if (key_press !== 1'b0) begin bad++; $display("FAIL midrst_key_press got=%b want=0", key_press); end
        repeat (2) @(negedge clk);
        base = press_cnt;
        RSTn = 1'b1;
        cyc  = 0;
        goto(47);
        total++; if (onehot !== 16'h0000) begin bad++; $display("FAIL midrst_early got=%h want=0000", onehot); end
        goto(48);
        total++; if (onehot !== 16'h0400) begin bad++; $display("FAIL midrst_commit got=%h want=0400", onehot); end
        total++; if (key_press !== 1'b1) begin bad++; $display("FAIL midrst_pulse got=%b want=1", key_press); end
        goto(64);
        total++; if (press_cnt - base != 1) begin bad++; $display("FAIL midrst_presses got=%0d want=1", press_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_key();
        test_short_press();
        test_multi_key();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each row is driven (1 ms at 50 MHz); legal range >= 4.
REQ-002 Parameter DEBOUNCE_FRAMES, default 5, consecutive identical scan frames needed to commit a code; legal range 2..15.
REQ-003 Port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 Port RSTn  input  1  reset, asynchronous assert, active-low.
REQ-005 Port col_n  input  4  keypad column returns, externally pulled up; 0 means the driven row connects to this column.
REQ-006 Port row_n  output  4  keypad row drives, active-low, exactly one bit low at any time.
REQ-007 Port onehot  output  16  debounced key code; bit 4*row+col is set while exactly that key is held; 16'h0000 means no valid key.
REQ-008 Port key_press  output  1  one-cycle pulse in the cycle onehot changes to a new non-zero value.

Function
REQ-009 col_n SHALL pass through a 2-flop synchronizer before any use.
REQ-010 A row counter SHALL drive row r (row_n[r]=0) for SCAN_DIV cycles, then advance r to (r+1) mod 4; row 3 wraps to row 0.
REQ-011 Synchronized columns SHALL be sampled once per row, in the last cycle of that row's period; key (r,c) is pressed when sampled column c is 0.
REQ-012 Four samples (rows 0..3) SHALL form a 16-bit frame snapshot, completed in the row-3 sample cycle (one frame = 4*SCAN_DIV cycles).
REQ-013 At each frame end, a snapshot equal to the previous snapshot SHALL increment the stable counter (saturating at DEBOUNCE_FRAMES); an unequal one SHALL reset it to 1.
REQ-014 The debounce FSM SHALL have states IDLE, PEND_PRESS, HELD and PEND_RELEASE.
REQ-015 IDLE: a non-zero snapshot SHALL move to PEND_PRESS.
REQ-016 PEND_PRESS: a zero snapshot SHALL return to IDLE; once the stable count reaches DEBOUNCE_FRAMES, the FSM SHALL move to HELD and commit the snapshot.
REQ-017 HELD: a snapshot that differs from the committed code SHALL move to PEND_RELEASE.
REQ-018 PEND_RELEASE: a snapshot equal to the committed code SHALL return to HELD; the same snapshot stable for DEBOUNCE_FRAMES frames SHALL commit it (HELD if non-zero, IDLE if zero).
REQ-019 A committed snapshot with exactly one bit set SHALL drive onehot; zero or two or more bits set (multi-key/ghosting) SHALL drive onehot=16'h0000.
REQ-020 onehot SHALL change only at commit, registered, one cycle after the frame-end sample cycle.
REQ-021 key_press SHALL pulse with that onehot update only when the new onehot is non-zero and differs from the old value; a direct change from key A to key B SHALL pulse once.
REQ-022 A bounce shorter than DEBOUNCE_FRAMES frames SHALL leave onehot and key_press unchanged.

Reset
REQ-023 While RSTn=0: row_n=4'b1110, onehot=16'h0000, key_press=0, FSM=IDLE, row and divider counters=0, snapshots=0, stable count=0, synchronizer=4'b1111.
REQ-024 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame; scanning SHALL restart at row 0 on the first clk edge after release.

Structure
REQ-025 Package keypad_pkg SHALL hold KP_ROWS=4, KP_COLS=4, default SCAN_DIV/DEBOUNCE_FRAMES values, and the debounce-state type.
REQ-026 Debounce FSM, stable counter and commit/pulse logic SHALL form sub-module keypad_debounce (frame in, onehot/key_press out); synchronizer, row scan and frame assembly stay in keypad_scan.

Verification (bench: SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles)
REQ-027 Reset release, no key -> row_n sequence 1110,1101,1011,0111 each 4 cycles, repeating; onehot=0; key_press never pulses.
REQ-028 Key (row 2, col 1) held 10 frames -> onehot=16'h0200 after 3rd stable frame end + 1 cycle; exactly one key_press; release held 3 frames -> onehot=16'h0000, no pulse.
REQ-029 Key (0,0) pressed for 2 frames, released -> onehot stays 16'h0000, no key_press.
REQ-030 Keys (1,0) and (1,3) held together 5 frames -> onehot=16'h0000, no key_press.
REQ-031 Key (3,3) committed (onehot=16'h8000), then slide to (0,2) without release -> onehot=16'h0004 after 3 stable frames, one key_press.
REQ-032 RSTn pulsed low during PEND_PRESS for key (2,2) -> all outputs at reset values immediately; after release, onehot=16'h0400 only after 3 new stable frames.
